// File: rtl/cpu31_trace_pkg.sv
// Shared CPU31 commit-trace definitions: record layout, error-field bits, checker state encoding.
// The simulation dump/compare tooling imports this package as well.
package cpu31_trace_pkg;

  localparam int REC_W       = 102;
  localparam int PC_LSB      = 70;
  localparam int INSTR_LSB   = 38;
  localparam int WB_EN_BIT   = 37;
  localparam int WB_ADDR_LSB = 32;
  localparam int WB_DATA_LSB = 0;

  localparam int ERR_PC      = 0;
  localparam int ERR_INSTR   = 1;
  localparam int ERR_WB_ADDR = 2;
  localparam int ERR_WB_DATA = 3;

  localparam logic [1:0] ST_PRIME = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd3;

  // A write to $0 is architecturally a no-op, so it counts as no write at all.
  function automatic logic eff_wb_en(input logic en, input logic [4:0] addr);
    return en & (addr != 5'd0);
  endfunction

endpackage

// File: rtl/trace_prefetch_fifo.sv
// Two-entry prefetch buffer for golden records with in-flight credit tracking.
// ROM data is pushed exactly one cycle after each read strobe.
module trace_prefetch_fifo
  import cpu31_trace_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             pop_i,
  input  logic [REC_W-1:0] data_i,
  output logic             rd_en_o,
  output logic [REC_W-1:0] head_o,
  output logic             empty_o,
  output logic             push_o
);

  logic [REC_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             infl_q;

  assign push_o  = infl_q;
  assign head_o  = head_q;
  assign empty_o = (cnt_q == 2'd0);

  // A pop this cycle frees a slot before the returning word lands, so it also grants credit.
  assign rd_en_o = rst_n & req_i &
                   (((({1'b0, cnt_q}) + {2'b00, infl_q}) < 3'd2) | pop_i);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({infl_q, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      infl_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      infl_q <= rd_en_o;
    end
  end

endmodule

// File: rtl/cpu_trace_checker.sv
// Compares the live CPU31 commit stream against golden records read from a ROM.
// Stalls the CPU while no golden record is buffered and freezes it on done or first mismatch.
module cpu_trace_checker
  import cpu31_trace_pkg::*;
#(
  parameter int N_REC  = 1100,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cm_valid,
  input  logic [31:0]       cm_pc,
  input  logic [31:0]       cm_instr,
  input  logic              cm_wb_en,
  input  logic [4:0]        cm_wb_addr,
  input  logic [31:0]       cm_wb_data,
  output logic              cpu_hold,
  output logic              gold_rd_en,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [REC_W-1:0]  gold_data,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] err_index,
  output logic [3:0]        err_field,
  output logic [ADDR_W:0]   match_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W:0]   N_ALL     = (ADDR_W+1)'(N_REC);
  localparam logic [ADDR_W:0]   N_PEN     = (ADDR_W+1)'(N_REC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_REC - 1);
  localparam logic [ADDR_W:0]   ONE       = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   issued_q, issued_d, match_q, match_d;
  logic [ADDR_W-1:0] err_idx_q, err_idx_d;
  logic [3:0]        err_fld_q, err_fld_d, diff;
  logic [REC_W-1:0]  head;
  logic              empty, pushing, pop, fetch_req, g_en, a_en;

  assign fetch_req = (issued_q != N_ALL);
  assign cpu_hold  = (state_q != ST_RUN) | empty;
  assign pop       = cm_valid & ~cpu_hold;
  assign gold_addr = fetch_req ? issued_q[ADDR_W-1:0] : LAST_ADDR;
  assign done      = (state_q == ST_DONE);
  assign fail      = (state_q == ST_FAIL);
  assign err_index = err_idx_q;
  assign err_field = err_fld_q;
  assign match_cnt = match_q;
  assign dbg_state = state_q;

  trace_prefetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (fetch_req),
    .pop_i   (pop),
    .data_i  (gold_data),
    .rd_en_o (gold_rd_en),
    .head_o  (head),
    .empty_o (empty),
    .push_o  (pushing)
  );

  always_comb begin
    diff = 4'b0000;
    g_en = eff_wb_en(head[WB_EN_BIT], head[WB_ADDR_LSB +: 5]);
    a_en = eff_wb_en(cm_wb_en, cm_wb_addr);
    diff[ERR_PC]    = (head[PC_LSB +: 32] != cm_pc);
    diff[ERR_INSTR] = (head[INSTR_LSB +: 32] != cm_instr);
    if (g_en != a_en) begin
      diff[ERR_WB_ADDR] = 1'b1;
    end else if (g_en) begin
      diff[ERR_WB_ADDR] = (head[WB_ADDR_LSB +: 5] != cm_wb_addr);
      diff[ERR_WB_DATA] = (head[WB_DATA_LSB +: 32] != cm_wb_data);
    end
  end

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    err_idx_d = err_idx_q;
    err_fld_d = err_fld_q;
    issued_d  = issued_q + {{ADDR_W{1'b0}}, gold_rd_en};
    case (state_q)
      // Leave PRIME on the push edge so the first record is usable immediately.
      ST_PRIME: if (!empty || pushing) state_d = ST_RUN;
      ST_RUN: begin
        if (pop) begin
          if (diff == 4'b0000) begin
            match_d = match_q + ONE;
            if (match_q == N_PEN) state_d = ST_DONE;
          end else begin
            state_d   = ST_FAIL;
            err_idx_d = match_q[ADDR_W-1:0];
            err_fld_d = diff;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_PRIME;
      issued_q  <= '0;
      match_q   <= '0;
      err_idx_q <= '0;
      err_fld_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      match_q   <= match_d;
      err_idx_q <= err_idx_d;
      err_fld_q <= err_fld_d;
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: 1-cycle golden ROM model, CPU commit driver and match-count scoreboard.
module tb_cpu_trace_checker;

  localparam int N_REC  = 8;
  localparam int ADDR_W = 11;

  logic              clk, rst_n;
  logic              cm_valid, cm_wb_en;
  logic [31:0]       cm_pc, cm_instr, cm_wb_data;
  logic [4:0]        cm_wb_addr;
  logic              cpu_hold, gold_rd_en, done, fail;
  logic [ADDR_W-1:0] gold_addr, err_index;
  logic [101:0]      gold_data;
  logic [3:0]        err_field;
  logic [ADDR_W:0]   match_cnt;
  logic [1:0]        dbg_state;

  logic [101:0]      rom [16];
  logic [101:0]      act [16];
  logic [ADDR_W:0]   exp_q [$];
  int                vectors, miscompares;
  int                cpu_idx, m_cnt;
  bit                m_fail, m_done;
  logic [ADDR_W-1:0] next_addr;

  cpu_trace_checker #(.N_REC(N_REC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_instr(cm_instr),
    .cm_wb_en(cm_wb_en), .cm_wb_addr(cm_wb_addr), .cm_wb_data(cm_wb_data),
    .cpu_hold(cpu_hold), .gold_rd_en(gold_rd_en), .gold_addr(gold_addr), .gold_data(gold_data),
    .done(done), .fail(fail), .err_index(err_index), .err_field(err_field),
    .match_cnt(match_cnt), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (gold_rd_en) gold_data <= rom[gold_addr[3:0]];

  // Fetch order monitor: every read strobe must request the next record, never beyond the last.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      next_addr = '0;
    end else if (gold_rd_en) begin
      vectors++;
      if (gold_addr !== next_addr || gold_addr > ADDR_W'(N_REC - 1)) begin
        miscompares++;
        $display("FAIL gold_addr: got %0d want %0d", gold_addr, next_addr);
      end
      next_addr = next_addr + 1'b1;
    end
  end

  function automatic logic [3:0] model_err(input logic [101:0] g, input logic [101:0] a);
    logic ge, ae;
    logic [3:0] r;
    r = 4'b0000;
    if (g[101:70] != a[101:70]) r[0] = 1'b1;
    if (g[69:38] != a[69:38]) r[1] = 1'b1;
    ge = g[37] && (g[36:32] != 5'd0);
    ae = a[37] && (a[36:32] != 5'd0);
    if (ge != ae) r[2] = 1'b1;
    else if (ge) begin
      if (g[36:32] != a[36:32]) r[2] = 1'b1;
      if (g[31:0] != a[31:0]) r[3] = 1'b1;
    end
    return r;
  endfunction

  task automatic load_records();
    for (int i = 0; i < 16; i++)
      rom[i] = {32'h00400000 + 32'(4 * i), $urandom(), 1'b1, 5'($urandom_range(1, 31)), $urandom()};
    rom[0] = {32'h00400000, 32'h3c1d1001, 1'b1, 5'd29, 32'h10010000};
    rom[5][69:38] = 32'h3c1d1001;
    for (int i = 0; i < 16; i++) act[i] = rom[i];
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; cm_valid = 1'b0;
    cpu_idx = 0; m_cnt = 0; m_fail = 0; m_done = 0;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_and_prime(output int cnt);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (cpu_hold === 1'b1 && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  // One CPU cycle; a commit counts when presented while cpu_hold is low.
  task automatic drive_cycle(input logic v, output logic acc);
    int k;
    logic [3:0] e;
    @(negedge clk);
    k   = (cpu_idx < N_REC) ? cpu_idx : N_REC - 1;
    acc = v && (cpu_hold === 1'b0) && (cpu_idx < N_REC);
    cm_valid = v;
    {cm_pc, cm_instr, cm_wb_en, cm_wb_addr, cm_wb_data} = act[k];
    if (acc) begin
      e = model_err(rom[k], act[k]);
      if (!m_fail && !m_done) begin
        if (e == 4'b0000) begin
          m_cnt++;
          if (m_cnt == N_REC) m_done = 1;
        end else m_fail = 1;
      end
      exp_q.push_back((ADDR_W+1)'(m_cnt));
      if (e == 4'b0000) cpu_idx++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    load_records();
    do_reset(2);
    vectors++;
    if ({cpu_hold, done, fail, gold_rd_en} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 1000", {cpu_hold, done, fail, gold_rd_en});
    end
    vectors++;
    if ({err_index, err_field, match_cnt, gold_addr, dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got idx %0d fld %b cnt %0d addr %0d st %0d want all 0",
               err_index, err_field, match_cnt, gold_addr, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    int cnt, bubbles;
    logic acc;
    logic [ADDR_W:0] e;
    release_and_prime(cnt);
    vectors++;
    if (cnt != 2) begin
      miscompares++;
      $display("FAIL prime_hold_cycles: got %0d want 2", cnt);
    end
    bubbles = 0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, acc);
      if (!acc) bubbles++;
      if (acc) begin
        e = exp_q.pop_front(); vectors++;
        if (match_cnt !== e) begin miscompares++; $display("FAIL match_cnt: got %0d want %0d", match_cnt, e); end
      end
    end
    vectors++;
    if (bubbles != 0 || match_cnt !== 4) begin
      miscompares++;
      $display("FAIL back_to_back: got bubbles %0d cnt %0d want 0 and 4", bubbles, match_cnt);
    end
  endtask

  task automatic test_done();
    logic acc;
    logic [ADDR_W:0] e;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, acc);
      if (acc) begin
        e = exp_q.pop_front(); vectors++;
        if (match_cnt !== e || done !== (m_cnt == N_REC)) begin
          miscompares++;
          $display("FAIL done_edge: got cnt %0d done %b want %0d %b", match_cnt, done, e, m_cnt == N_REC);
        end
      end
    end
    vectors++;
    if ({done, fail, cpu_hold, dbg_state} !== {3'b101, 2'd2} || match_cnt !== N_REC) begin
      miscompares++;
      $display("FAIL done_final: got d%b f%b h%b st%0d cnt %0d want d1 f0 h1 st2 cnt 8",
               done, fail, cpu_hold, dbg_state, match_cnt);
    end
  endtask

  task automatic test_instr_mismatch();
    int cnt;
    logic acc;
    logic [ADDR_W:0] e;
    load_records();
    act[5][69:38] = 32'h00000000;
    do_reset(1);
    release_and_prime(cnt);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, acc);
      if (acc) begin
        e = exp_q.pop_front(); vectors++;
        if (match_cnt !== e) begin miscompares++; $display("FAIL match_cnt: got %0d want %0d", match_cnt, e); end
      end
    end
    vectors++;
    if ({fail, done, cpu_hold} !== 3'b101 || err_index !== 5 || err_field !== 4'b0010 || match_cnt !== 5) begin
      miscompares++;
      $display("FAIL instr_mismatch: got f%b d%b h%b idx %0d fld %b cnt %0d want f1 d0 h1 idx 5 fld 0010 cnt 5",
               fail, done, cpu_hold, err_index, err_field, match_cnt);
    end
  endtask

  task automatic test_wb_norm();
    int cnt;
    logic acc;
    logic [ADDR_W:0] e;
    load_records();
    rom[1][37] = 1'b0;  act[1][37] = 1'b1; act[1][36:32] = 5'd0;
    rom[2][36:32] = 5'd0; act[2][37] = 1'b0; act[2][31:0] = ~rom[2][31:0];
    rom[4][37:0] = {1'b1, 5'd8, 32'd5};
    act[4] = rom[4]; act[4][36:32] = 5'd9;
    do_reset(1);
    release_and_prime(cnt);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, acc);
      if (acc) begin
        e = exp_q.pop_front(); vectors++;
        if (match_cnt !== e) begin miscompares++; $display("FAIL match_cnt: got %0d want %0d", match_cnt, e); end
      end
    end
    vectors++;
    if (fail !== 1'b1 || err_index !== 4 || err_field !== 4'b0100 || match_cnt !== 4) begin
      miscompares++;
      $display("FAIL wb_norm: got f%b idx %0d fld %b cnt %0d want f1 idx 4 fld 0100 cnt 4",
               fail, err_index, err_field, match_cnt);
    end
  endtask

  task automatic test_gaps();
    int cnt;
    logic acc;
    logic [ADDR_W:0] e;
    load_records();
    do_reset(1);
    release_and_prime(cnt);
    for (int k = 0; k < 40; k++) begin
      drive_cycle((k % 4 == 0) || (k % 4 == 3), acc);
      if (acc) begin
        e = exp_q.pop_front(); vectors++;
        if (match_cnt !== e) begin miscompares++; $display("FAIL match_cnt: got %0d want %0d", match_cnt, e); end
      end
    end
    vectors++;
    if ({done, fail} !== 2'b10 || match_cnt !== N_REC || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL gaps: got d%b f%b cnt %0d pend %0d want d1 f0 cnt 8 pend 0",
               done, fail, match_cnt, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int cnt, guard;
    logic acc;
    logic [ADDR_W:0] e;
    load_records();
    do_reset(1);
    release_and_prime(cnt);
    guard = 0;
    while (m_cnt < 3 && guard < 20) begin
      drive_cycle(1'b1, acc);
      if (acc) begin
        e = exp_q.pop_front(); vectors++;
        if (match_cnt !== e) begin miscompares++; $display("FAIL match_cnt: got %0d want %0d", match_cnt, e); end
      end
      guard++;
    end
    do_reset(1);
    vectors++;
    if ({cpu_hold, done, fail, gold_rd_en} !== 4'b1000 || {err_index, err_field, match_cnt, gold_addr} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got h%b d%b f%b rd%b idx %0d fld %b cnt %0d addr %0d want 1000 and zeros",
               cpu_hold, done, fail, gold_rd_en, err_index, err_field, match_cnt, gold_addr);
    end
    release_and_prime(cnt);
    vectors++;
    if (cnt != 2) begin miscompares++; $display("FAIL rerun_prime: got %0d want 2", cnt); end
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, acc);
      if (acc) begin
        e = exp_q.pop_front(); vectors++;
        if (match_cnt !== e) begin miscompares++; $display("FAIL match_cnt: got %0d want %0d", match_cnt, e); end
      end
    end
    vectors++;
    if ({done, fail} !== 2'b10 || match_cnt !== N_REC) begin
      miscompares++;
      $display("FAIL rerun: got d%b f%b cnt %0d want d1 f0 cnt 8", done, fail, match_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; cm_valid = 1'b0; cm_pc = '0; cm_instr = '0;
    cm_wb_en = 1'b0; cm_wb_addr = '0; cm_wb_data = '0;
    vectors = 0; miscompares = 0;
    test_reset();
    test_back_to_back();
    test_done();
    test_instr_mismatch();
    test_wb_norm();
    test_gaps();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
